// File: rtl/crc5_pkg.sv
// Shared CRC-5 definitions: 64-bit word, polynomial x^5+x^2+1, zero seed,
// MSB-first, no reflection and no final XOR.
package crc5_pkg;

  localparam int          DATA_W = 64;
  localparam int          CRC_W  = 5;
  localparam logic [4:0]  POLY   = 5'h05;

  function automatic logic [CRC_W-1:0] crc5_d64(input logic [DATA_W-1:0] data);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = '0;
    // Unrolled serial LFSR; synthesis flattens this to XOR trees per bit.
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ data[i];
      c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : 5'h00);
    end
    return c;
  endfunction

endpackage

// File: rtl/rr_arbiter_nreq.sv
// Combinational round-robin arbiter: first asserted request at or above ptr,
// wrapping modulo NREQ. The pointer itself lives in the parent.
module rr_arbiter_nreq #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_id
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;
  logic            found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NREQ)) sum = sum - (ID_W+1)'(NREQ);
      idx = sum[ID_W-1:0];
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

endmodule

// File: rtl/crc5_req_arbiter.sv
// Round-robin sharing of one CRC-5 engine across NREQ requesters, with a
// single registered response stage. Optional CRC5_CHECK_EN adds req_crc/rsp_err.
module crc5_req_arbiter
  import crc5_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*64-1:0] req_data,
`ifdef CRC5_CHECK_EN
  input  logic [NREQ*5-1:0]  req_crc,
  output logic               rsp_err,
`endif
  output logic [NREQ-1:0]    req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [4:0]         rsp_crc,
  output logic [63:0]        rsp_data
);

  logic              can_accept;
  logic              en;
  logic              xfer;
  logic [NREQ-1:0]   gnt;
  logic [ID_W-1:0]   gnt_id;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   ptr_next;
  logic [DATA_W-1:0] word;
  logic [CRC_W-1:0]  crc;

  // Refill is allowed in the same cycle the held response drains.
  assign can_accept = !rsp_valid || rsp_ready;
  assign en         = can_accept && !rst;

  rr_arbiter_nreq #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .req    (req_valid),
    .ptr    (ptr),
    .en     (en),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;
  assign ptr_next  = (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

  always_comb begin
    word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) word = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign crc = crc5_d64(word);

`ifdef CRC5_CHECK_EN
  logic [CRC_W-1:0] exp_crc;

  always_comb begin
    exp_crc = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) exp_crc = req_crc[i*CRC_W +: CRC_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_err <= 1'b0;
    end else if (xfer) begin
      rsp_err <= (crc != exp_crc);
    end
  end
`endif

  // Response stage: payload holds its last value after a drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_crc   <= '0;
      rsp_data  <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      rsp_valid <= 1'b1;
      rsp_id    <= gnt_id;
      rsp_crc   <= crc;
      rsp_data  <= word;
      ptr       <= ptr_next;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_crc5_req_arbiter.sv
// Directed bench for crc5_req_arbiter (NREQ=4); expected CRCs are hand-derived
// from x^(k+5) mod (x^5+x^2+1) for single-bit words.
module tb_crc5_req_arbiter;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*64-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [4:0]         rsp_crc;
  logic [63:0]        rsp_data;
`ifdef CRC5_CHECK_EN
  logic [NREQ*5-1:0]  req_crc;
  logic               rsp_err;
`endif

  int n_assert;
  int n_fail;

  crc5_req_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
`ifdef CRC5_CHECK_EN
    .req_crc   (req_crc),
    .rsp_err   (rsp_err),
`endif
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_crc   (rsp_crc),
    .rsp_data  (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic [ID_W-1:0] id,
                           input logic [4:0] crc, input logic [63:0] data);
    check({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    check({tag, "_id"},    64'(rsp_id),    64'(id));
    check({tag, "_crc"},   64'(rsp_crc),   64'(crc));
    check({tag, "_data"},  rsp_data,       data);
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b1;
`ifdef CRC5_CHECK_EN
    req_crc   = '0;
`endif
    step();
    step();
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_id",    64'(rsp_id),    64'd0);
    check("rst_crc",   64'(rsp_crc),   64'd0);
    check("rst_data",  rsp_data,       64'd0);
    req_valid = 4'b1111;
    #1;
    check("rst_ready_low", 64'(req_ready), 64'd0);
    req_valid = '0;
    rst = 1'b0;

    // Single word from requester 0
    req_data[0 +: 64] = 64'h1;
    req_valid = 4'b0001;
    #1;
    check("single_ready", 64'(req_ready), 64'b0001);
    step();
    req_valid = '0;
    check_rsp("single", 2'd0, 5'h05, 64'h1);

    // Bit 63 then zero from requester 2 (ptr now 1)
    req_data[128 +: 64] = 64'h8000_0000_0000_0000;
    req_valid = 4'b0100;
    #1;
    check("b63_ready", 64'(req_ready), 64'b0100);
    step();
    check_rsp("b63", 2'd2, 5'h0A, 64'h8000_0000_0000_0000);
    req_data[128 +: 64] = 64'h0;
    step();
    check_rsp("zero", 2'd2, 5'h00, 64'h0);

    // Linearity: 64'h3 -> 05 ^ 0A
    req_valid = 4'b0010;
    req_data[64 +: 64] = 64'h3;
    step();
    check_rsp("w3", 2'd1, 5'h0F, 64'h3);

    // Drain without refill
    req_valid = '0;
    step();
    check("drain_valid", 64'(rsp_valid), 64'd0);
    check("drain_id_hold", 64'(rsp_id), 64'd1);
    check("drain_data_hold", rsp_data, 64'h3);

    // Reset so round robin starts from requester 0
    rst = 1'b1;
    #2;
    rst = 1'b0;
    req_data  = {64'h8, 64'h4, 64'h2, 64'h1};
    req_valid = 4'b1111;
    step(); check_rsp("rr0", 2'd0, 5'h05, 64'h1);
    step(); check_rsp("rr1", 2'd1, 5'h0A, 64'h2);
    step(); check_rsp("rr2", 2'd2, 5'h14, 64'h4);
    step(); check_rsp("rr3", 2'd3, 5'h0D, 64'h8);
    step(); check_rsp("rr4", 2'd0, 5'h05, 64'h1);
    step(); check_rsp("rr5", 2'd1, 5'h0A, 64'h2);

    // Backpressure with response from requester 1 held
    rsp_ready = 1'b0;
    #1;
    check("bp_ready0", 64'(req_ready), 64'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      check_rsp("bp_hold", 2'd1, 5'h0A, 64'h2);
      check("bp_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(req_ready), 64'b0100);
    step();
    check_rsp("bp_next", 2'd2, 5'h14, 64'h4);

    // Asynchronous reset between edges while a response is held
    #2;
    rst = 1'b1;
    #1;
    check("amid_valid", 64'(rsp_valid), 64'd0);
    check("amid_id",    64'(rsp_id),    64'd0);
    check("amid_data",  rsp_data,       64'd0);
    check("amid_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;
    req_valid = 4'b1000 | 4'b0001;
    #1;
    check("post_rst_ready", 64'(req_ready), 64'b0001);
    step();
    check_rsp("post_rst", 2'd0, 5'h05, 64'h1);

`ifdef CRC5_CHECK_EN
    req_valid = 4'b0001;
    req_data[0 +: 64] = 64'h1;
    req_crc[0 +: 5] = 5'h05;
    step();
    step();
    check("err_ok", 64'(rsp_err), 64'd0);
    req_crc[0 +: 5] = 5'h04;
    step();
    check("err_bad", 64'(rsp_err), 64'd1);
`endif

    req_valid = '0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
